// File: rtl/step_pattern_sequencer.sv
// rtl/step_pattern_sequencer.sv - pattern step sequencer feeding the 12-note generator
// Optional STACCATO_GATE_EN: gates Select off for the second half of each step.
module step_pattern_sequencer #(
    parameter int STEPS  = 16,
    parameter int STEP_W = 4,
    parameter int TDIV_W = 26
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              play_i,
    input  logic [TDIV_W-1:0] tempo_div_i,
    input  logic              wr_en_i,
    input  logic [STEP_W-1:0] wr_step_i,
    input  logic [11:0]       wr_notes_i,
    output logic [11:0]       select_o,
    output logic              nstart_o,
    output logic [STEP_W-1:0] step_o,
    output logic              step_pulse_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PLAY = 1'b1;

    logic [11:0]       pattern_q [STEPS];
    logic [0:0]        state_q, state_d;
    logic [TDIV_W-1:0] counter_q, counter_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [11:0]       select_q, select_d;
    logic              nstart_q, nstart_d;
    logic              pulse_q, pulse_d;

    logic [TDIV_W-1:0] eff_div;
    logic              advance;
    logic              load;
    logic [STEP_W-1:0] load_addr;
    logic [11:0]       load_mask;
    logic [11:0]       held_mask;
    logic [11:0]       mask_d;

    assign eff_div = (tempo_div_i == '0) ? TDIV_W'(1) : tempo_div_i;
    // >= keeps a lowered tempo from letting the counter run past the boundary
    assign advance = (counter_q >= eff_div - TDIV_W'(1));

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        step_d    = step_q;
        load      = 1'b0;
        load_addr = step_q + STEP_W'(1);
        case (state_q)
            S_IDLE: begin
                counter_d = '0;
                step_d    = '0;
                if (play_i) begin
                    state_d   = S_PLAY;
                    load      = 1'b1;
                    load_addr = '0;
                end
            end
            default: begin
                if (!play_i) begin
                    state_d   = S_IDLE;
                    counter_d = '0;
                    step_d    = '0;
                end else if (advance) begin
                    counter_d = '0;
                    step_d    = step_q + STEP_W'(1);
                    load      = 1'b1;
                end else begin
                    counter_d = counter_q + TDIV_W'(1);
                end
            end
        endcase
    end

    // Write-first bypass so a write landing on the loading step is heard at once
    assign load_mask = (wr_en_i && (wr_step_i == load_addr)) ? wr_notes_i
                                                             : pattern_q[load_addr];
    assign mask_d    = (state_d == S_PLAY) ? (load ? load_mask : held_mask) : 12'h000;
    assign nstart_d  = (state_d == S_PLAY);
    assign pulse_d   = load;

`ifdef STACCATO_GATE_EN
    logic [11:0]       mask_q;
    logic [TDIV_W-1:0] half_div;
    logic              gate_open;

    assign held_mask = mask_q;
    assign half_div  = eff_div >> 1;
    assign gate_open = (half_div == '0) || (counter_d < half_div);
    assign select_d  = gate_open ? mask_d : 12'h000;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end
`else
    assign held_mask = select_q;
    assign select_d  = mask_d;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < STEPS; i++) begin
                pattern_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            pattern_q[wr_step_i] <= wr_notes_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            counter_q <= '0;
            step_q    <= '0;
            select_q  <= '0;
            nstart_q  <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            step_q    <= step_d;
            select_q  <= select_d;
            nstart_q  <= nstart_d;
            pulse_q   <= pulse_d;
        end
    end

    assign select_o     = select_q;
    assign nstart_o     = nstart_q;
    assign step_o       = step_q;
    assign step_pulse_o = pulse_q;

endmodule

// File: tb/tb_step_pattern_sequencer.sv
// tb/tb_step_pattern_sequencer.sv - bench for step_pattern_sequencer with behavioural model
module tb_step_pattern_sequencer;

    localparam int STEPS  = 16;
    localparam int STEP_W = 4;
    localparam int TDIV_W = 26;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              play = 1'b0;
    logic [TDIV_W-1:0] tempo = '0;
    logic              wr_en = 1'b0;
    logic [STEP_W-1:0] wr_step = '0;
    logic [11:0]       wr_notes = '0;
    logic [11:0]       select;
    logic              nstart;
    logic [STEP_W-1:0] step;
    logic              step_pulse;

    int checks = 0;
    int failures = 0;

    // Model: playing flag, current step, clocks elapsed since step load, loaded mask
    int m_pat [STEPS];
    bit m_valid = 0;
    bit m_playing = 0;
    int m_step = 0;
    int m_el = 0;
    int m_mask = 0;
    int m_pulse = 0;
    int m_eff = 1;

    step_pattern_sequencer #(.STEPS(STEPS), .STEP_W(STEP_W), .TDIV_W(TDIV_W)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .play_i      (play),
        .tempo_div_i (tempo),
        .wr_en_i     (wr_en),
        .wr_step_i   (wr_step),
        .wr_notes_i  (wr_notes),
        .select_o    (select),
        .nstart_o    (nstart),
        .step_o      (step),
        .step_pulse_o(step_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        if (reset) begin
            for (int i = 0; i < STEPS; i++) m_pat[i] = 0;
            m_valid = 1; m_playing = 0; m_step = 0; m_el = 0; m_mask = 0; m_pulse = 0;
        end else begin
            if (wr_en) m_pat[wr_step] = int'(wr_notes);
            m_eff = (tempo == 0) ? 1 : int'(tempo);
            m_pulse = 0;
            if (!m_playing) begin
                if (play) begin
                    m_playing = 1; m_step = 0; m_el = 0; m_mask = m_pat[0]; m_pulse = 1;
                end
            end else if (!play) begin
                m_playing = 0; m_step = 0; m_el = 0; m_mask = 0;
            end else if (m_el + 1 >= m_eff) begin
                m_step = (m_step + 1) % STEPS; m_el = 0; m_mask = m_pat[m_step]; m_pulse = 1;
            end else begin
                m_el++;
            end
        end
    endtask

    function automatic int model_select();
        if (!m_playing) return 0;
`ifdef STACCATO_GATE_EN
        if ((m_eff / 2) != 0 && m_el >= (m_eff / 2)) return 0;
`endif
        return m_mask;
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
        if (m_valid) begin
            chk("model_select", int'(select), model_select());
            chk("model_nstart", int'(nstart), m_playing ? 1 : 0);
            chk("model_step", int'(step), m_step);
            chk("model_pulse", int'(step_pulse), m_pulse);
        end
    endtask

    task automatic restart(input int tdiv);
        play = 1'b0;
        cyc();
        tempo = TDIV_W'(tdiv);
        play = 1'b1;
        cyc();
    endtask

    task automatic write_pat(input int addr, input int notes);
        wr_en = 1'b1; wr_step = STEP_W'(addr); wr_notes = 12'(notes);
        cyc();
        wr_en = 1'b0;
    endtask

    initial begin
        cyc();
        chk("rst_select", int'(select), 0);
        chk("rst_nstart", int'(nstart), 0);
        chk("rst_step", int'(step), 0);
        chk("rst_pulse", int'(step_pulse), 0);
        reset = 1'b0;

        write_pat(0, 'h001);
        write_pat(1, 'h010);
        write_pat(2, 'h880);
        tempo = 4; play = 1'b1;
        cyc();
        chk("t1_k0_select", int'(select), 'h001);
        chk("t1_k0_pulse", int'(step_pulse), 1);
        chk("t1_k0_nstart", int'(nstart), 1);
        for (int k = 1; k <= 15; k++) begin
            cyc();
            if (k == 4) chk("t1_k4_select", int'(select), 'h010);
            if (k == 4) chk("t1_k4_pulse", int'(step_pulse), 1);
            if (k == 5) chk("t1_k5_pulse", int'(step_pulse), 0);
            if (k == 8) chk("t1_k8_select", int'(select), 'h880);
            if (k == 12) chk("t1_k12_select", int'(select), 0);
            if (k == 12) chk("t1_k12_step", int'(step), 3);
        end

        restart(2);
        for (int k = 1; k <= 32; k++) begin
            cyc();
            if (k == 30) chk("t2_k30_step", int'(step), 15);
            if (k == 32) chk("t2_wrap_step", int'(step), 0);
            if (k == 32) chk("t2_wrap_select", int'(select), 'h001);
        end

        restart(4);
        for (int k = 1; k <= 72; k++) begin
            wr_en = (k == 10) || (k == 12);
            wr_step = (k == 12) ? STEP_W'(3) : STEP_W'(2);
            wr_notes = (k == 12) ? 12'h0A5 : 12'hFFF;
            cyc();
            if (k == 10) chk("t3_hold_select", int'(select), 'h880);
            if (k == 12) chk("t3_bypass_select", int'(select), 'h0A5);
            if (k == 72) chk("t3_reload_select", int'(select), 'hFFF);
        end
        wr_en = 1'b0;

        restart(0);
        for (int k = 1; k <= 5; k++) cyc();
        chk("t4_div0_pulse", int'(step_pulse), 1);
        chk("t4_div0_step", int'(step), 5);
        restart(1);
        for (int k = 1; k <= 5; k++) cyc();
        chk("t4_div1_pulse", int'(step_pulse), 1);
        restart(100);
        for (int k = 1; k <= 50; k++) cyc();
        chk("t4_slow_step", int'(step), 0);
        tempo = 3;
        cyc();
        chk("t4_lower_step", int'(step), 1);
        chk("t4_lower_pulse", int'(step_pulse), 1);

        restart(4);
        for (int k = 1; k <= 5; k++) cyc();
        play = 1'b0;
        cyc();
        chk("t5_stop_select", int'(select), 0);
        chk("t5_stop_nstart", int'(nstart), 0);
        play = 1'b1;
        cyc(); cyc(); cyc();
        reset = 1'b1; wr_en = 1'b1; wr_step = 5; wr_notes = 12'hFFF;
        cyc();
        chk("t5_rst_select", int'(select), 0);
        chk("t5_rst_nstart", int'(nstart), 0);
        chk("t5_rst_step", int'(step), 0);
        chk("t5_rst_pulse", int'(step_pulse), 0);
        reset = 1'b0; wr_en = 1'b0; tempo = 1;
        cyc();
        for (int k = 1; k <= 16; k++) begin
            cyc();
            chk("t5_cleared_select", int'(select), 0);
        end

`ifdef STACCATO_GATE_EN
        write_pat(0, 'h003);
        restart(8);
        for (int k = 1; k <= 15; k++) begin
            cyc();
            chk("sg_gate_select", int'(select), ((k % 8) < 4) ? 'h003 : 0);
        end
        restart(1);
        chk("sg_div1_select", int'(select), 'h003);
`endif

        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(199) == 0);
            play = ($urandom_range(15) != 0);
            if ($urandom_range(49) == 0) tempo = TDIV_W'($urandom_range(6));
            wr_en = ($urandom_range(2) == 0);
            wr_step = STEP_W'($urandom_range(STEPS - 1));
            wr_notes = 12'($urandom_range(4095));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/step_pattern_sequencer.md
Name: step_pattern_sequencer

Overview:
Upstream stage of the 12-note audio generator. Stores a STEPS-deep pattern of 12-bit note masks (bit 0 = C … bit 11 = B) and, while playing, steps through it at a programmable tempo. It drives the generator's 12-bit note-select input and its active-low oscillator start. It also provides the current step index and a step strobe for the display/UI logic.

Parameters:
STEPS, 16, number of pattern steps (power of two, >= 2)
STEP_W, 4, step index width, = log2(STEPS)
TDIV_W, 26, width of tempo divider (clocks per step)

Ports:
Clock  input  1  system clock
Reset  input  1  synchronous active-high reset
Play  input  1  level; 1 = run sequence, 0 = stop
Tempo_div  input  TDIV_W  clocks per step; 0 treated as 1
Wr_en  input  1  pattern write strobe
Wr_step  input  STEP_W  pattern address to write
Wr_notes  input  12  note mask to write
Select  output  12  registered note mask for the audio generator
nStart  output  1  registered oscillator enable, active-low reset to generator NCOs
Step  output  STEP_W  registered current step index
Step_pulse  output  1  one-cycle strobe on each step load

Behaviour:
- One clock, synchronous active-high Reset. All state changes on posedge Clock.
- Reset (overrides everything, including a coincident Wr_en):
  - pattern RAM cleared to all zeros; state = IDLE; step counter = 0.
  - outputs: Select = 0, nStart = 0, Step = 0, Step_pulse = 0.
  - Reset asserted mid-play gives the same result on the next edge.
- Pattern RAM: STEPS x 12 flops.
  - Wr_en=1 writes Wr_notes to pattern[Wr_step] at the clock edge. Writes are accepted in any state.
- States: IDLE, PLAY.
- IDLE:
  - Select = 0, nStart = 0, Step = 0, counter = 0, Step_pulse = 0.
  - Play=1 sampled -> next edge: state = PLAY, Select = pattern[0], Step = 0, Step_pulse = 1, nStart = 1, counter = 0.
- PLAY:
  - counter increments each clock.
  - Step advance when counter >= eff_div-1, where eff_div = max(Tempo_div, 1). On that edge:
    - counter <= 0; Step <= Step+1, wrapping from STEPS-1 to 0.
    - Select <= pattern[new step]; Step_pulse <= 1.
  - Otherwise Step_pulse = 0, and Select holds.
  - Using >= means a Tempo_div lowered below the running counter advances on the next edge and the counter never runs away.
  - Resulting step period = eff_div clocks. Tempo_div=1 advances every clock, with Step_pulse held high continuously.
- Play=0 sampled in PLAY -> next edge: IDLE with Select = 0, nStart = 0, Step = 0, counter = 0, Step_pulse = 0. Play=0 has priority over a coincident step advance.
- Write/read collisions:
  - Select is sampled from the pattern only at step load. A write to the currently sounding step does not change Select until that step is next loaded.
  - A write coincident with a load of the same address uses the new Wr_notes (write-first bypass).
- nStart stays 1 throughout PLAY, so generator phase is continuous across steps. It drops to 0 only in IDLE/Reset.
- Latency: Play rise to first Select = 1 clock. Step boundary to Select update = same edge as the Step change.

Optional Feature:
Macro STACCATO_GATE_EN.
- Defined: within each step, Select = pattern mask while counter < (eff_div >> 1) and 0 for the remainder of the step. If eff_div >> 1 == 0, the gate is never closed. Step, Step_pulse and nStart are unaffected.
- Undefined: Select holds the mask for the full step (legato), as specified above.

Test Plan:
- Reset, write pattern[0]=0x001, [1]=0x010, [2]=0x880, Tempo_div=4, Play=1 -> Select sequence 0x001 x4 clk, 0x010 x4, 0x880 x4, then 0x000 for steps 3..15; Step_pulse every 4 clk; nStart=1 from first PLAY cycle.
- STEPS=16, Tempo_div=2, run 33 steps -> Step wraps 15->0 and Select returns to pattern[0] after exactly 32 clk.
- While step 2 sounds, write pattern[2]=0xFFF -> Select stays 0x880 until step 2 is reloaded, then 0xFFF. Write pattern[3]=0x0A5 on the same edge step 3 loads -> Select=0x0A5 immediately.
- Tempo_div=0 and Tempo_div=1 -> advance every clock, Step_pulse held 1. Change Tempo_div 100->3 when counter=50 -> advance on next edge.
- Play dropped mid-step, and separately Reset mid-play with coincident Wr_en -> next edge Select=0, nStart=0, Step=0, Step_pulse=0. After Reset all pattern entries read 0.
- With STACCATO_GATE_EN, Tempo_div=8, pattern[0]=0x003 -> Select=0x003 for 4 clk then 0x000 for 4 clk per step. Tempo_div=1 -> Select never gated.
